regfile_master: RTL and testbench
=================================

# regfile_master

Command-side initiator for the 16×32 register file. It accepts read, write and read-write commands over a valid/ready interface and drives the register file's `EN`/`RD`/`WR`/select/data pins for exactly one cycle per command. For reads, it waits out the register file's registered read latency, captures `op1`/`op2`, and returns them over a valid/ready response channel. It sits between the datapath sequencer and the register file, so no other block toggles register-file controls directly.

## Interface
Parameters:
- `DATA_W`, 32: data width; must match the register file.
- `ADDR_W`, 4: register select width (16 registers).
- `RD_LAT`, 1: edges from the register file sampling `RD` to `op1`/`op2` being valid; legal range 1–4.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: block can accept a command.
- `cmd_op`  in  2: 0 NOP, 1 WRITE, 2 READ, 3 READ_WRITE.
- `cmd_wsel`  in  ADDR_W: write register index.
- `cmd_rsel1`, `cmd_rsel2`  in  ADDR_W: read register indices.
- `cmd_wdata`  in  DATA_W: write data.
- `rsp_valid`  out  1: read response present.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_data1`, `rsp_data2`  out  DATA_W: captured read data.
- `rf_EN`, `rf_RD`, `rf_WR`  out  1: register-file controls.
- `rf_sel_i1`, `rf_sel_o1`, `rf_sel_o2`  out  ADDR_W: register-file selects.
- `rf_Ip1`  out  DATA_W: register-file write data.
- `rf_op1`, `rf_op2`  in  DATA_W: register-file read outputs.

## Operation
- States:
  - `IDLE`: `cmd_ready` = 1.
  - `ISSUE`: drive the register file for one cycle.
  - `WAIT`: wait for read data.
  - `RESP`: hold the response until consumed.
- A command is accepted on a rising edge with `cmd_valid && cmd_ready`. All command fields are registered on that edge.
- `IDLE` transitions:
  - NOP: accepted and discarded; stay in `IDLE` with `cmd_ready` held at 1, so back-to-back NOPs are accepted every cycle.
  - WRITE, READ, READ_WRITE: go to `ISSUE`.
- `ISSUE`:
  - Drive `rf_EN` = 1, `rf_WR` = `op[0]`, `rf_RD` = `op[1]`.
  - Drive `rf_sel_i1`, `rf_sel_o1`, `rf_sel_o2` and `rf_Ip1` from the registered command.
  - Next state: `IDLE` for WRITE, `WAIT` otherwise.
- `WAIT`:
  - `rf_EN`/`RD`/`WR` = 0.
  - A down-counter loaded with `RD_LAT` counts the cycles.
  - On the edge ending the last `WAIT` cycle, capture `rf_op1`/`rf_op2` into `rsp_data1`/`rsp_data2`, then go to `RESP`.
- `RESP`:
  - `rsp_valid` = 1, with the data held stable.
  - On `rsp_valid && rsp_ready`, go to `IDLE`.
- READ_WRITE with `cmd_wsel` equal to a read select returns the pre-write value. The register file samples the read and the write on the same edge.
- Outside `ISSUE`: `rf_EN`/`rf_RD`/`rf_WR` = 0. Selects and `rf_Ip1` hold their last values.
- WRITE never produces a response.

## Timing
- All outputs are registered.
- Reset values:
  - state = `IDLE`.
  - `cmd_ready` = 0; it rises on the first clock edge after `rst` deasserts.
  - `rsp_valid` = 0 and `rsp_data1`/`rsp_data2` = 0.
  - `rf_EN`, `rf_RD`, `rf_WR` = 0; all selects = 0; `rf_Ip1` = 0.
- Command accepted on edge E0:
  - `ISSUE` spans E0 to E1.
  - `rsp_valid` rises after edge E(1+`RD_LAT`), i.e. E2 at default.
- Write throughput: `cmd_ready` is low for exactly one cycle per write, so one write every 2 cycles.
- Read turnaround (default `RD_LAT`): `cmd_ready` returns high on the edge that accepts the response. Minimum is 4 cycles per read when `rsp_ready` is held high.
- No combinational path from `cmd_valid` or `rsp_ready` to any output.
- Reset mid-operation, in any state:
  - All outputs take their reset values immediately (asynchronous).
  - The in-flight command is dropped with no response and no further register-file activity.

## Structure
- Shared package `regfile_pkg` holds:
  - op encodings (`OP_NOP`, `OP_WRITE`, `OP_READ`, `OP_RW`);
  - the 2-bit state encoding;
  - default `DATA_W`/`ADDR_W`, which the register file also uses.
- No sub-module: a single FSM with a `RD_LAT` counter and capture registers.
- The bench pairs this block with the existing register file.

## Test plan
- Reset, then:
  - WRITE `0xABCDEFAB` to r0;
  - WRITE `0x01234567` to r1;
  - READ (0,1) → `rsp_data1` = `0xABCDEFAB`, `rsp_data2` = `0x01234567`, with `rsp_valid` high 2 edges after acceptance.
- r3 = `0x11`; READ_WRITE with `wsel` = `rsel1` = 3 and `wdata` = `0x22` → `rsp_data1` = `0x11`. A following READ of r3 → `0x22`.
- READ with `rsp_ready` held low for 5 cycles:
  - `rsp_valid` and the data stay stable;
  - `cmd_ready` stays 0;
  - `rf_EN` stays 0;
  - accepted on the cycle `rsp_ready` rises.
- `rst` pulsed during `WAIT`:
  - `rsp_valid` and `rf_EN` go to 0 immediately;
  - `cmd_ready` stays 0 until the first edge after deassert;
  - no stale response ever appears.
- Three consecutive NOPs → accepted on 3 consecutive edges; `rf_EN` never asserts.
- Back-to-back WRITEs to r5, r6 → `cmd_ready` low exactly one cycle each; `rf_WR` pulses are one cycle wide; readback returns both values.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the 16x32 register file and its command-side master:
// default geometry, command opcodes and the master's state encoding.
package regfile_pkg;

  // Default geometry shared with the register file itself.
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 4;

  // Command opcodes as seen on cmd_op. Bit 0 requests a write and bit 1
  // requests a read, so READ_WRITE is both.
  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_RW    = 2'd3
  } op_e;

  // Master FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_master_if.sv
// Bundle for the register-file master: command channel, response channel and
// the register-file pin group. The master modport is the regfile_master view.
// The slave modport is the sequencer/register-file side.
interface regfile_master_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);

  // Command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_wsel;
  logic [ADDR_W-1:0] cmd_rsel1;
  logic [ADDR_W-1:0] cmd_rsel2;
  logic [DATA_W-1:0] cmd_wdata;

  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data1;
  logic [DATA_W-1:0] rsp_data2;

  // Register-file pins
  logic              rf_EN;
  logic              rf_RD;
  logic              rf_WR;
  logic [ADDR_W-1:0] rf_sel_i1;
  logic [ADDR_W-1:0] rf_sel_o1;
  logic [ADDR_W-1:0] rf_sel_o2;
  logic [DATA_W-1:0] rf_Ip1;
  logic [DATA_W-1:0] rf_op1;
  logic [DATA_W-1:0] rf_op2;

  modport master (
    input  cmd_valid, cmd_op, cmd_wsel, cmd_rsel1, cmd_rsel2, cmd_wdata,
    input  rsp_ready,
    input  rf_op1, rf_op2,
    output cmd_ready,
    output rsp_valid, rsp_data1, rsp_data2,
    output rf_EN, rf_RD, rf_WR, rf_sel_i1, rf_sel_o1, rf_sel_o2, rf_Ip1
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_wsel, cmd_rsel1, cmd_rsel2, cmd_wdata,
    output rsp_ready,
    output rf_op1, rf_op2,
    input  cmd_ready,
    input  rsp_valid, rsp_data1, rsp_data2,
    input  rf_EN, rf_RD, rf_WR, rf_sel_i1, rf_sel_o1, rf_sel_o2, rf_Ip1
  );

endinterface

// File: rtl/regfile_master.sv
// Command-side initiator for the register file. It accepts one command,
// pulses the register-file controls for a single cycle, and waits out the
// registered read latency. For reads, it then holds the captured operands on
// the response channel until they are consumed. Every output is a flop, so
// neither cmd_valid nor rsp_ready reaches an output combinationally.
module regfile_master
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  // Edges from the register file sampling RD to op1/op2 being valid (1..4).
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  regfile_master_if.master   bus
);

  // Wide enough to hold RD_LAT up to 4.
  localparam int CNT_W = 3;

  state_e            state_q,     state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data1_q, rsp_data1_d;
  logic [DATA_W-1:0] rsp_data2_q, rsp_data2_d;
  logic              rf_en_q,     rf_en_d;
  logic              rf_rd_q,     rf_rd_d;
  logic              rf_wr_q,     rf_wr_d;
  logic [ADDR_W-1:0] sel_i1_q,    sel_i1_d;
  logic [ADDR_W-1:0] sel_o1_q,    sel_o1_d;
  logic [ADDR_W-1:0] sel_o2_q,    sel_o2_d;
  logic [DATA_W-1:0] ip1_q,       ip1_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  op_e  cmd_op;
  logic cmd_fire;
  logic rsp_fire;

  assign cmd_op   = op_e'(bus.cmd_op);
  assign cmd_fire = bus.cmd_valid && cmd_ready_q;
  assign rsp_fire = rsp_valid_q && bus.rsp_ready;

  // Next-state and next-output logic for the command FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data1_d = rsp_data1_q;
    rsp_data2_d = rsp_data2_q;
    rf_en_d     = 1'b0;
    rf_rd_d     = 1'b0;
    rf_wr_d     = 1'b0;
    sel_i1_d    = sel_i1_q;
    sel_o1_d    = sel_o1_q;
    sel_o2_d    = sel_o2_q;
    ip1_d       = ip1_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        // Ready rises on the first edge after reset and stays up across NOPs.
        cmd_ready_d = 1'b1;
        if (cmd_fire && cmd_op != OP_NOP) begin
          state_d     = ST_ISSUE;
          cmd_ready_d = 1'b0;
          rf_en_d     = 1'b1;
          rf_wr_d     = bus.cmd_op[0];
          rf_rd_d     = bus.cmd_op[1];
          sel_i1_d    = bus.cmd_wsel;
          sel_o1_d    = bus.cmd_rsel1;
          sel_o2_d    = bus.cmd_rsel2;
          ip1_d       = bus.cmd_wdata;
        end
      end

      ST_ISSUE: begin
        // The register file samples the controls on this edge. A pure write
        // is done, and anything with a read waits for the data.
        if (rf_rd_q) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(RD_LAT);
        end else begin
          state_d     = ST_IDLE;
          cmd_ready_d = 1'b1;
        end
      end

      ST_WAIT: begin
        // On the edge ending the last wait cycle the operands are valid.
        if (cnt_q == CNT_W'(1)) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_data1_d = bus.rf_op1;
          rsp_data2_d = bus.rf_op2;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RESP: begin
        // Ready returns on the same edge that hands off the response.
        if (rsp_fire) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data1_q <= '0;
      rsp_data2_q <= '0;
      rf_en_q     <= 1'b0;
      rf_rd_q     <= 1'b0;
      rf_wr_q     <= 1'b0;
      sel_i1_q    <= '0;
      sel_o1_q    <= '0;
      sel_o2_q    <= '0;
      ip1_q       <= '0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // values, which keeps the update order-independent.
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data1_q <= rsp_data1_d;
      rsp_data2_q <= rsp_data2_d;
      rf_en_q     <= rf_en_d;
      rf_rd_q     <= rf_rd_d;
      rf_wr_q     <= rf_wr_d;
      sel_i1_q    <= sel_i1_d;
      sel_o1_q    <= sel_o1_d;
      sel_o2_q    <= sel_o2_d;
      ip1_q       <= ip1_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data1 = rsp_data1_q;
  assign bus.rsp_data2 = rsp_data2_q;
  assign bus.rf_EN     = rf_en_q;
  assign bus.rf_RD     = rf_rd_q;
  assign bus.rf_WR     = rf_wr_q;
  assign bus.rf_sel_i1 = sel_i1_q;
  assign bus.rf_sel_o1 = sel_o1_q;
  assign bus.rf_sel_o2 = sel_o2_q;
  assign bus.rf_Ip1    = ip1_q;

endmodule

// File: tb/tb_regfile_master.sv
// Directed bench for regfile_master paired with a behavioural 16x32 register
// file. The register file has a one-edge registered read, and a write and a
// read on the same edge return the old value.
module tb_regfile_master;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_master_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  regfile_master #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural register file
  logic [31:0] rf_mem [16];
  logic [31:0] op1_r = '0;
  logic [31:0] op2_r = '0;
  assign bus.rf_op1 = op1_r;
  assign bus.rf_op2 = op2_r;

  always @(posedge clk) begin
    if (bus.rf_EN && bus.rf_WR) rf_mem[bus.rf_sel_i1] <= bus.rf_Ip1;
    if (bus.rf_EN && bus.rf_RD) begin
      op1_r <= rf_mem[bus.rf_sel_o1];
      op2_r <= rf_mem[bus.rf_sel_o2];
    end
  end

  // Activity monitors: edges on which rf_EN or rsp_valid was high.
  int en_count  = 0;
  int rsp_count = 0;
  always @(posedge clk) begin
    if (bus.rf_EN)     en_count  <= en_count + 1;
    if (bus.rsp_valid) rsp_count <= rsp_count + 1;
  end

  int errors = 0;
  int checks = 0;

  // Present a command and return one step after the edge that accepts it.
  task automatic issue(input logic [1:0] op, input logic [3:0] ws,
                       input logic [3:0] r1, input logic [3:0] r2,
                       input logic [31:0] wd);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_wsel  = ws;
    bus.cmd_rsel1 = r1;
    bus.cmd_rsel2 = r2;
    bus.cmd_wdata = wd;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL issue_timeout: cmd_ready=%b after %0d cycles, need 1", bus.cmd_ready, n);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Issue a read-type command, wait for the response, and consume it.
  task automatic do_read(input logic [1:0] op, input logic [3:0] ws,
                         input logic [3:0] r1, input logic [3:0] r2,
                         input logic [31:0] wd,
                         output logic [31:0] d1, output logic [31:0] d2,
                         output int lat);
    issue(op, ws, r1, r2, wd);
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    d1 = bus.rsp_data1;
    d2 = bus.rsp_data2;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_wsel  = '0;
    bus.cmd_rsel1 = '0;
    bus.cmd_rsel2 = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rf_EN, bus.rf_RD, bus.rf_WR} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rdy/vld/en/rd/wr=%b, need 00000",
               {bus.cmd_ready, bus.rsp_valid, bus.rf_EN, bus.rf_RD, bus.rf_WR});
    end
    checks++;
    if ({bus.rsp_data1, bus.rsp_data2, bus.rf_Ip1, bus.rf_sel_i1, bus.rf_sel_o1, bus.rf_sel_o2} !== '0) begin
      errors++;
      $display("FAIL reset_data: d1=%h d2=%h ip1=%h sel=%h/%h/%h, need all 0",
               bus.rsp_data1, bus.rsp_data2, bus.rf_Ip1, bus.rf_sel_i1, bus.rf_sel_o1, bus.rf_sel_o2);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: cmd_ready=%b right after deassert, need 0", bus.cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: cmd_ready=%b after first edge, need 1", bus.cmd_ready);
    end
  endtask

  task automatic test_write_read;
    logic [31:0] d1, d2;
    int lat;
    issue(OP_WRITE, 4'd0, 4'd0, 4'd0, 32'hABCDEFAB);
    checks++;
    if ({bus.rf_EN, bus.rf_WR, bus.rf_RD, bus.cmd_ready} !== 4'b1100 ||
        bus.rf_sel_i1 !== 4'd0 || bus.rf_Ip1 !== 32'hABCDEFAB) begin
      errors++;
      $display("FAIL write_issue: en/wr/rd/rdy=%b sel_i1=%h ip1=%h, need 1100 0 abcdefab",
               {bus.rf_EN, bus.rf_WR, bus.rf_RD, bus.cmd_ready}, bus.rf_sel_i1, bus.rf_Ip1);
    end
    issue(OP_WRITE, 4'd1, 4'd0, 4'd0, 32'h01234567);
    do_read(OP_READ, 4'd0, 4'd0, 4'd1, 32'd0, d1, d2, lat);
    checks++;
    if (d1 !== 32'hABCDEFAB || d2 !== 32'h01234567) begin
      errors++;
      $display("FAIL read_01: d1=%h d2=%h, need abcdefab 01234567", d1, d2);
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL read_latency: rsp_valid %0d edges after accept, need 2", lat);
    end
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_handoff: cmd_ready=%b rsp_valid=%b, need 1 0", bus.cmd_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_read_write;
    logic [31:0] d1, d2;
    int lat;
    issue(OP_WRITE, 4'd3, 4'd0, 4'd0, 32'h11);
    do_read(OP_RW, 4'd3, 4'd3, 4'd0, 32'h22, d1, d2, lat);
    checks++;
    if (d1 !== 32'h11 || d2 !== 32'hABCDEFAB) begin
      errors++;
      $display("FAIL rw_prewrite: d1=%h d2=%h, need 00000011 abcdefab", d1, d2);
    end
    do_read(OP_READ, 4'd0, 4'd3, 4'd3, 32'd0, d1, d2, lat);
    checks++;
    if (d1 !== 32'h22 || d2 !== 32'h22) begin
      errors++;
      $display("FAIL rw_after: d1=%h d2=%h, need 00000022 00000022", d1, d2);
    end
  endtask

  task automatic test_backpressure;
    int n;
    int bad;
    n   = 0;
    bad = 0;
    issue(OP_READ, 4'd0, 4'd1, 4'd0, 32'd0);
    while (bus.rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_valid: rsp_valid=%b after %0d cycles, need 1", bus.rsp_valid, n);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.rf_EN !== 1'b0 ||
          bus.rsp_data1 !== 32'h01234567 || bus.rsp_data2 !== 32'hABCDEFAB) begin
        bad++;
        $display("FAIL bp_hold cycle %0d: vld=%b rdy=%b en=%b d1=%h d2=%h, need 1 0 0 01234567 abcdefab",
                 i, bus.rsp_valid, bus.cmd_ready, bus.rf_EN, bus.rsp_data1, bus.rsp_data2);
      end
    end
    checks++;
    if (bad != 0) errors++;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept: rsp_valid=%b cmd_ready=%b, need 0 1", bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  // Pulse reset either in ISSUE (wait_cycles=0) or in WAIT (wait_cycles=1).
  task automatic test_reset_mid(input int wait_cycles);
    int en0, rsp0;
    issue(OP_READ, 4'd0, 4'd0, 4'd1, 32'd0);
    repeat (wait_cycles) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rf_EN !== 1'b0 || bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid%0d_async: vld=%b en=%b rdy=%b, need 0 0 0",
               wait_cycles, bus.rsp_valid, bus.rf_EN, bus.cmd_ready);
    end
    en0  = en_count;
    rsp0 = rsp_count;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid%0d_ready_low: cmd_ready=%b, need 0", wait_cycles, bus.cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid%0d_ready_rise: cmd_ready=%b, need 1", wait_cycles, bus.cmd_ready);
    end
    repeat (6) begin
      @(posedge clk); #1;
    end
    checks++;
    if (en_count != en0 || rsp_count != rsp0) begin
      errors++;
      $display("FAIL rst_mid%0d_stale: en edges=%0d rsp edges=%0d after reset, need 0 0",
               wait_cycles, en_count - en0, rsp_count - rsp0);
    end
  endtask

  task automatic test_nop;
    int accepted, en0;
    accepted = 0;
    en0      = en_count;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_NOP;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) accepted++;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (accepted != 3) begin
      errors++;
      $display("FAIL nop_accept: accepted on %0d of 3 edges, need 3", accepted);
    end
    checks++;
    if (en_count != en0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL nop_quiet: en edges=%0d cmd_ready=%b, need 0 1", en_count - en0, bus.cmd_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  rdy_trace, wr_trace;
    logic [31:0] d1, d2;
    int lat;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_WRITE;
    bus.cmd_wsel  = 4'd5;
    bus.cmd_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    bus.cmd_wsel  = 4'd6;
    bus.cmd_wdata = 32'h0F0F0F0F;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rdy_trace[3-i] = bus.cmd_ready;
      wr_trace[3-i]  = bus.rf_WR;
      @(posedge clk); #1;
      if (i == 1) bus.cmd_valid = 1'b0;
    end
    checks++;
    if (rdy_trace !== 4'b0101) begin
      errors++;
      $display("FAIL b2b_ready: cmd_ready trace=%b, need 0101", rdy_trace);
    end
    checks++;
    if (wr_trace !== 4'b1010) begin
      errors++;
      $display("FAIL b2b_wr_pulse: rf_WR trace=%b, need 1010", wr_trace);
    end
    do_read(OP_READ, 4'd0, 4'd5, 4'd6, 32'd0, d1, d2, lat);
    checks++;
    if (d1 !== 32'h55AA55AA || d2 !== 32'h0F0F0F0F) begin
      errors++;
      $display("FAIL b2b_readback: d1=%h d2=%h, need 55aa55aa 0f0f0f0f", d1, d2);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_write();
    test_backpressure();
    test_reset_mid(0);
    test_reset_mid(1);
    test_nop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the sequence itself stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
